mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the machine's single-port synchronous RAM between the CPU and a second bus master (program loader / DMA). Requests use a hold-until-ack handshake. The arbiter latches the winning request and sequences one RAM access per grant. It returns read data and a one-cycle acknowledge. It sits inside `machine`, between `m_cpu`, the loader and `m_ram`.

## Interface
- `ADDR_WIDTH`, default 8, RAM address width.
- `DATA_WIDTH`, default 8, RAM data width.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `c_req`, `d_req`  in  1  CPU / DMA request; held high until ack sampled.
- `c_we`, `d_we`  in  1  1 = write, 0 = read.
- `c_addr`, `d_addr`  in  ADDR_WIDTH  request address.
- `c_wdata`, `d_wdata`  in  DATA_WIDTH  write data.
- `c_rdata`, `d_rdata`  out  DATA_WIDTH  read data to each port.
- `c_ack`, `d_ack`  out  1  one-cycle completion pulse.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after the address edge.
- `owner`  out  2  current grant: 00 none, 01 CPU, 10 DMA.

## Operation
- FSM states are IDLE, ACCESS and DONE; the reset state is IDLE.
- **IDLE:** if any request is present, pick a winner, then go to ACCESS.
  - When both ports request, the CPU wins.
  - On grant, latch the winner's addr/we/wdata into registers and set `owner`.
  - With no request, stay in IDLE.
- **ACCESS:** the latched values drive `mem_addr`/`mem_wdata`, and `mem_we` = latched we. Always go to DONE.
- **DONE:** the owner's ack is high.
  - For a read, the owner's rdata = `mem_rdata`, and is also captured into that port's rdata holding register.
  - **Next state:** if the *other* port requests, grant it (latch, then ACCESS). Otherwise go to IDLE with `owner` = 00.
  - The current owner's still-high request is ignored in DONE. This alternation makes starvation impossible.
- `mem_we` is high only in ACCESS and only for write grants. `mem_addr`/`mem_wdata` hold their latched values outside ACCESS.
- rdata outputs hold the last value read by that port. Writes never change rdata.
- Inputs are latched at grant. A request dropped after grant still completes and still acks. Port inputs changing after grant do not affect the access.
- **Reset (reset = 0 at an edge), including mid-ACCESS or mid-DONE:**
  - state goes to IDLE; `owner`, acks, `mem_we`, `mem_addr`, `mem_wdata` and both rdata registers go to 0.
  - A write in ACCESS at the reset edge is not committed, because `mem_we` is 0 after the edge.

## Timing
- Reset values: all outputs 0.
- **Latency:** a request present at edge E0 (arbiter in IDLE) gives ACCESS in cycle E0–E1, with the RAM op at E1. DONE and ack follow in cycle E1–E2. The requester samples ack/rdata at E2 and may deassert req after E2.
- A single access takes 3 cycles (IDLE, ACCESS, DONE) from an idle request to next idle.
- Back-to-back alternating ports: one access per 2 cycles (DONE → ACCESS).
- The same port re-requesting immediately after its ack returns via IDLE: 3 cycles per access.
- Each ack is high for exactly one cycle per granted request.

## Structure
- Shared package `machine_pkg`: state encoding (IDLE=0, ACCESS=1, DONE=2) and owner codes (NONE=00, CPU=01, DMA=10).
- A single flat module. No sub-module is needed; the RAM stays in `m_ram`.

## Test plan
- **Reset:** drive reset=0 for 2 cycles with c_req=1. Required: all outputs 0, `mem_we` never 1, `owner`=00.
- **CPU write then read:**
  - c_req write, addr 0x10, data 0xA5. Required: `mem_we`=1 with `mem_addr`=0x10 for exactly one cycle, then c_ack one cycle.
  - Then a read of 0x10. Required: c_ack at cycle E1–E2 with `c_rdata`=0xA5, held after c_req drops.
- **Simultaneous requests:** c_req read 0x20, and d_req write 0x21 ← 0x3C, in the same cycle.
  - Required: CPU is served first, then DMA directly from DONE (no IDLE).
  - Acks arrive 2 cycles apart; RAM[0x21]=0x3C.
- **Fairness:** CPU requests continuously (re-asserting after each ack) while DMA holds d_req. Required: the DMA ack arrives at most 4 cycles after its request; grants alternate CPU/DMA.
- **Latched inputs:** change `d_addr` from 0x40 to 0x41 during ACCESS. Required: the write lands at 0x40 only.
- **Mid-op reset:** assert reset during ACCESS of a write to 0x50 ← 0xFF. Required: RAM[0x50] unchanged, no ack, IDLE after the edge.

Source files
------------

// File: rtl/machine_pkg.sv
// Shared definitions for the machine: arbiter state encoding, bus owner codes
// and a small helper used to find the alternate port.
package machine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  // The port that gets priority once the current owner has been served.
  function automatic owner_e other_port(input owner_e cur);
    owner_e res;
    case (cur)
      OWN_CPU: res = OWN_DMA;
      OWN_DMA: res = OWN_CPU;
      default: res = OWN_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the single-port synchronous RAM between the CPU and
// the loader/DMA master; one RAM access per grant, alternating under contention.
module mem_arbiter
  import machine_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  d_req,
  input  logic                  c_we,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  c_ack,
  output logic                  d_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner
);

  arb_state_e            state_r;
  arb_state_e            state_next_s;
  owner_e                owner_r;
  owner_e                owner_next_s;
  logic                  grant_s;
  owner_e                grant_port_s;
  logic                  other_req_s;
  logic                  done_read_s;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  we_r;
  logic [DATA_WIDTH-1:0] c_rdata_r;
  logic [DATA_WIDTH-1:0] d_rdata_r;

  // State and grant owner registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_NONE;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
    end
  end

  // Next-state and grant decision; the owner's own request is ignored in DONE.
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
    grant_s      = 1'b0;
    grant_port_s = OWN_NONE;
    if (other_port(owner_r) == OWN_DMA) begin
      other_req_s = d_req;
    end else if (other_port(owner_r) == OWN_CPU) begin
      other_req_s = c_req;
    end else begin
      other_req_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (c_req) begin
          grant_s      = 1'b1;
          grant_port_s = OWN_CPU;
          state_next_s = ST_ACCESS;
          owner_next_s = OWN_CPU;
        end else if (d_req) begin
          grant_s      = 1'b1;
          grant_port_s = OWN_DMA;
          state_next_s = ST_ACCESS;
          owner_next_s = OWN_DMA;
        end else begin
          state_next_s = ST_IDLE;
          owner_next_s = OWN_NONE;
        end
      end
      ST_ACCESS: begin
        state_next_s = ST_DONE;
        owner_next_s = owner_r;
      end
      ST_DONE: begin
        if (other_req_s) begin
          grant_s      = 1'b1;
          grant_port_s = other_port(owner_r);
          state_next_s = ST_ACCESS;
          owner_next_s = other_port(owner_r);
        end else begin
          state_next_s = ST_IDLE;
          owner_next_s = OWN_NONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        owner_next_s = OWN_NONE;
      end
    endcase
  end

  // Capture the winning request at grant time so later port changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      we_r    <= 1'b0;
    end else if (grant_s) begin
      if (grant_port_s == OWN_CPU) begin
        addr_r  <= c_addr;
        wdata_r <= c_wdata;
        we_r    <= c_we;
      end else begin
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
        we_r    <= d_we;
      end
    end
  end

  // Per-port read data holding registers, loaded when a read completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_rdata_r <= {DATA_WIDTH{1'b0}};
      d_rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (done_read_s) begin
      if (owner_r == OWN_CPU) begin
        c_rdata_r <= mem_rdata;
      end else if (owner_r == OWN_DMA) begin
        d_rdata_r <= mem_rdata;
      end
    end
  end

  // Output decode. mem_we is gated by reset so a write caught by reset
  // during ACCESS never reaches the RAM at that edge.
  always_comb begin
    done_read_s = (state_r == ST_DONE) && !we_r;
    c_ack       = (state_r == ST_DONE) && (owner_r == OWN_CPU);
    d_ack       = (state_r == ST_DONE) && (owner_r == OWN_DMA);
    mem_we      = (state_r == ST_ACCESS) && we_r && reset;
    mem_addr    = addr_r;
    mem_wdata   = wdata_r;
    owner       = owner_r;
    if (done_read_s && (owner_r == OWN_CPU)) begin
      c_rdata = mem_rdata;
    end else begin
      c_rdata = c_rdata_r;
    end
    if (done_read_s && (owner_r == OWN_DMA)) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = d_rdata_r;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a timestamp-based transaction model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_req, d_req, c_we, d_we;
  logic [7:0] c_addr, d_addr, c_wdata, d_wdata;
  logic [7:0] c_rdata, d_rdata, mem_addr, mem_wdata;
  logic       c_ack, d_ack, mem_we;
  logic [1:0] owner;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] ram [0:255] = '{default: 8'h00};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .d_req(d_req), .c_we(c_we), .d_we(d_we),
    .c_addr(c_addr), .d_addr(d_addr), .c_wdata(c_wdata), .d_wdata(d_wdata),
    .c_rdata(c_rdata), .d_rdata(d_rdata), .c_ack(c_ack), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Synchronous single-port RAM, read data valid the cycle after the address edge.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, cr, cwe;
    logic [7:0] ca, cd;
    logic       dr, dwe;
    logic [7:0] da, dd;
    logic       cack, dack;
    logic [1:0] own;
    logic       mwe;
    logic [7:0] maddr, mwd, crd, drd;
  } vec_t;

  function automatic vec_t mk(input logic rst, cr, cwe, input logic [7:0] ca, cd,
                              input logic dr, dwe, input logic [7:0] da, dd,
                              input logic cack, dack, input logic [1:0] own,
                              input logic mwe, input logic [7:0] maddr, mwd, crd, drd);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dwe = dwe; v.da = da; v.dd = dd;
    v.cack = cack; v.dack = dack; v.own = own; v.mwe = mwe;
    v.maddr = maddr; v.mwd = mwd; v.crd = crd; v.drd = drd;
    return v;
  endfunction

  // Transaction model: a grant at edge g does its RAM op at g+1, acks during
  // g+1..g+2, and at g+2 hands over to the other port only if it is waiting.
  int         t, g, m_gp;
  logic       m_lwe;
  logic [7:0] m_la, m_lwd, m_rd1, m_rd2;
  logic [7:0] m_mem [0:255];

  task automatic m_grant(input int p);
    m_gp = p;
    g = t;
    m_la  = (p == 1) ? c_addr  : d_addr;
    m_lwd = (p == 1) ? c_wdata : d_wdata;
    m_lwe = (p == 1) ? c_we    : d_we;
  endtask

  task automatic model_step();
    t = t + 1;
    if (!reset) begin
      m_gp = 0; g = -100; m_la = 8'h00; m_lwd = 8'h00; m_lwe = 1'b0;
      m_rd1 = 8'h00; m_rd2 = 8'h00;
    end else begin
      if (m_gp != 0 && t == g + 1) begin
        if (m_lwe) m_mem[m_la] = m_lwd;
        else if (m_gp == 1) m_rd1 = m_mem[m_la];
        else m_rd2 = m_mem[m_la];
      end
      if (m_gp == 0) begin
        if (c_req) m_grant(1);
        else if (d_req) m_grant(2);
      end else if (t == g + 2) begin
        if (m_gp == 1 && d_req) m_grant(2);
        else if (m_gp == 2 && c_req) m_grant(1);
        else m_gp = 0;
      end
    end
  endtask

  logic c_rel = 1'b0, d_rel = 1'b0;

  // Random requester honouring hold-until-ack.
  task automatic next_req(input logic ack, inout logic req, inout logic rel,
                          inout logic we, inout logic [7:0] a, inout logic [7:0] wd);
    if (req && ack) begin
      rel = 1'b1;
    end else if (rel) begin
      rel = 1'b0;
      req = ($urandom_range(0, 1) == 0);
      we = $urandom_range(0, 1) == 1; a = 8'h80 + 8'($urandom_range(0, 7)); wd = 8'($urandom);
    end else if (!req && $urandom_range(0, 2) == 0) begin
      req = 1'b1;
      we = $urandom_range(0, 1) == 1; a = 8'h80 + 8'($urandom_range(0, 7)); wd = 8'($urandom);
    end else if (req && $urandom_range(0, 7) == 0) begin
      a = 8'h80 + 8'($urandom_range(0, 7)); wd = 8'($urandom);
    end
  endtask

  vec_t tbl [14];
  int   seq [16];
  int   n_ack, lat;
  logic got;

  initial begin
    tbl[0]  = mk(0,1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,2'd0,0,8'h00,8'h00,8'h00,8'h00);
    tbl[1]  = mk(0,1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,2'd0,0,8'h00,8'h00,8'h00,8'h00);
    tbl[2]  = mk(1,1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,2'd1,1,8'h10,8'hA5,8'h00,8'h00);
    tbl[3]  = mk(1,1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0,2'd1,0,8'h10,8'hA5,8'h00,8'h00);
    tbl[4]  = mk(1,0,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,2'd0,0,8'h10,8'hA5,8'h00,8'h00);
    tbl[5]  = mk(1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,2'd1,0,8'h10,8'h00,8'h00,8'h00);
    tbl[6]  = mk(1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,2'd1,0,8'h10,8'h00,8'hA5,8'h00);
    tbl[7]  = mk(1,0,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,2'd0,0,8'h10,8'h00,8'hA5,8'h00);
    tbl[8]  = mk(1,1,0,8'h20,8'h00, 1,1,8'h21,8'h3C, 0,0,2'd1,0,8'h20,8'h00,8'hA5,8'h00);
    tbl[9]  = mk(1,1,0,8'h20,8'h00, 1,1,8'h21,8'h3C, 1,0,2'd1,0,8'h20,8'h00,8'h00,8'h00);
    tbl[10] = mk(1,1,0,8'h20,8'h00, 1,1,8'h21,8'h3C, 0,0,2'd2,1,8'h21,8'h3C,8'h00,8'h00);
    tbl[11] = mk(1,0,0,8'h20,8'h00, 1,1,8'h21,8'h3C, 0,1,2'd2,0,8'h21,8'h3C,8'h00,8'h00);
    tbl[12] = mk(1,0,0,8'h20,8'h00, 1,1,8'h21,8'h3C, 0,0,2'd0,0,8'h21,8'h3C,8'h00,8'h00);
    tbl[13] = mk(1,0,0,8'h20,8'h00, 0,1,8'h21,8'h3C, 0,0,2'd0,0,8'h21,8'h3C,8'h00,8'h00);

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst; c_req = tbl[i].cr; c_we = tbl[i].cwe;
      c_addr = tbl[i].ca; c_wdata = tbl[i].cd;
      d_req = tbl[i].dr; d_we = tbl[i].dwe; d_addr = tbl[i].da; d_wdata = tbl[i].dd;
      @(posedge clk); @(negedge clk);
      chk($sformatf("row%0d c_ack", i), 32'(c_ack), 32'(tbl[i].cack));
      chk($sformatf("row%0d d_ack", i), 32'(d_ack), 32'(tbl[i].dack));
      chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].own));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
      chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].mwd));
      chk($sformatf("row%0d c_rdata", i), 32'(c_rdata), 32'(tbl[i].crd));
      chk($sformatf("row%0d d_rdata", i), 32'(d_rdata), 32'(tbl[i].drd));
    end
    chk("ram_10", 32'(ram[8'h10]), 32'h0A5);
    chk("ram_21", 32'(ram[8'h21]), 32'h03C);

    // Fairness: both masters keep requesting; grants must alternate.
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h30;
    @(posedge clk); @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h31;
    n_ack = 0; lat = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      chk("fair_no_double_ack", 32'(c_ack && d_ack), 32'h0);
      if (c_ack || d_ack) begin
        seq[n_ack] = c_ack ? 1 : 2;
        n_ack++;
        if (d_ack && lat == 0) lat = k;
      end
    end
    chk("fair_dma_latency_le4", 32'(lat >= 1 && lat <= 4), 32'h1);
    chk("fair_ack_count", 32'(n_ack), 32'd8);
    for (int k = 0; k < n_ack; k++)
      chk($sformatf("fair_alt%0d", k), 32'(seq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    c_req = 1'b0; d_req = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("fair_idle_owner", 32'(owner), 32'h0);

    // Latched inputs: address changes during ACCESS must not move the write.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'h77;
    @(posedge clk); @(negedge clk);
    chk("latch_owner", 32'(owner), 32'h2);
    chk("latch_mem_addr", 32'(mem_addr), 32'h40);
    d_addr = 8'h41; d_wdata = 8'h11;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack) got = 1'b1;
    end
    chk("latch_ack_seen", 32'(got), 32'h1);
    @(posedge clk); @(negedge clk);
    d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("latch_ram_40", 32'(ram[8'h40]), 32'h77);
    chk("latch_ram_41", 32'(ram[8'h41]), 32'h00);

    // Reset arriving while a write sits in ACCESS.
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h50; c_wdata = 8'hFF;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_mem_we", 32'(mem_we), 32'h1);
    reset = 1'b0; c_req = 1'b0;
    #1;
    chk("rst_gated_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_c_ack", 32'(c_ack), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_c_rdata", 32'(c_rdata), 32'h0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_after_owner", 32'(owner), 32'h0);
    chk("rst_after_ack", 32'(c_ack), 32'h0);
    chk("rst_ram_50", 32'(ram[8'h50]), 32'h00);

    // Randomized traffic against the transaction model.
    for (int i = 0; i < 256; i++) m_mem[i] = ram[i];
    t = 0; g = -100; m_gp = 0;
    reset = 1'b0; c_req = 1'b0; d_req = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_owner", 32'(owner), 32'(m_gp));
      chk("rnd_c_ack", 32'(c_ack), 32'(m_gp == 1 && t == g + 1));
      chk("rnd_d_ack", 32'(d_ack), 32'(m_gp == 2 && t == g + 1));
      chk("rnd_mem_we", 32'(mem_we), 32'(m_gp != 0 && t == g && m_lwe && reset));
      chk("rnd_mem_addr", 32'(mem_addr), 32'(m_la));
      chk("rnd_mem_wdata", 32'(mem_wdata), 32'(m_lwd));
      chk("rnd_c_rdata", 32'(c_rdata), 32'(m_rd1));
      chk("rnd_d_rdata", 32'(d_rdata), 32'(m_rd2));
      next_req(c_ack, c_req, c_rel, c_we, c_addr, c_wdata);
      next_req(d_ack, d_req, d_rel, d_we, d_addr, d_wdata);
      reset = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      if (!reset) begin
        c_req = 1'b0; d_req = 1'b0; c_rel = 1'b0; d_rel = 1'b0;
      end
    end
    for (int i = 128; i < 136; i++)
      chk($sformatf("rnd_ram_%0h", i), 32'(ram[i]), 32'(m_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
